// File: rtl/duck_round_scheduler.sv
// Duck Hunt round scheduler: random spawn delays, flight supervision, shot/hit
// scoring and round progression. States: IDLE, SPAWN_WAIT, FLIGHT, RESULT, ROUND_END, FINISHED.
module duck_round_scheduler #(
  parameter int DUCKS_PER_ROUND = 10,
  parameter int SHOTS_PER_DUCK  = 3,
  parameter int PASS_HITS       = 6,
  parameter int MAX_ROUND       = 9,
  parameter int SPAWN_BASE      = 30,
  parameter int FLIGHT_TICKS    = 300,
  parameter int X_MIN           = 64,
  parameter int HIT_POINTS      = 100
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        game_enable_i,
  input  logic        frame_tick_i,
  input  logic [15:0] random_i,
  input  logic        left_mouse_i,
  input  logic        duck_hit_i,
  output logic        duck_spawn_o,
  output logic        duck_active_o,
  output logic [11:0] duck_xpos_start_o,
  output logic        duck_dir_o,
  output logic [3:0]  duck_speed_o,
  output logic [1:0]  shots_left_o,
  output logic [3:0]  hit_count_o,
  output logic [3:0]  duck_index_o,
  output logic [3:0]  round_o,
  output logic [15:0] score_o,
  output logic        game_finished_o
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_SPAWN_WAIT = 3'd1,
    S_FLIGHT     = 3'd2,
    S_RESULT     = 3'd3,
    S_ROUND_END  = 3'd4,
    S_FINISHED   = 3'd5
  } state_t;

  localparam logic [3:0]  DUCKS_C  = 4'(DUCKS_PER_ROUND);
  localparam logic [1:0]  SHOTS_C  = 2'(SHOTS_PER_DUCK);
  localparam logic [3:0]  PASS_C   = 4'(PASS_HITS);
  localparam logic [3:0]  MAXR_C   = 4'(MAX_ROUND);
  localparam logic [6:0]  BASE_C   = 7'(SPAWN_BASE);
  localparam logic [9:0]  FLIGHT_C = 10'(FLIGHT_TICKS);
  localparam logic [11:0] XMIN_C   = 12'(X_MIN);
  localparam logic [16:0] POINTS_C = 17'(HIT_POINTS);

  state_t      state_q, state_d;
  logic [6:0]  delay_q, delay_d;
  logic [9:0]  flight_q, flight_d;
  logic        mouse_q, mouse_d;
  logic        hit_q, hit_d;
  logic        spawn_q, spawn_d;
  logic        active_q, active_d;
  logic [11:0] xpos_q, xpos_d;
  logic        dir_q, dir_d;
  logic [3:0]  speed_q, speed_d;
  logic [1:0]  shots_q, shots_d;
  logic [3:0]  hits_q, hits_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  round_q, round_d;
  logic [15:0] score_q, score_d;
  logic        finished_q, finished_d;

  logic        shot;
  logic [6:0]  delay_load;
  logic [16:0] score_sum;
  logic        unused_random;

  assign shot          = left_mouse_i & ~mouse_q;
  assign delay_load    = BASE_C + {2'b00, random_i[4:0]};
  assign score_sum     = {1'b0, score_q} + POINTS_C;
  assign unused_random = ^random_i[14:9];

  always_comb begin
    state_d  = state_q;
    delay_d  = delay_q;
    flight_d = flight_q;
    mouse_d  = left_mouse_i;
    hit_d    = hit_q;
    spawn_d  = 1'b0;
    xpos_d   = xpos_q;
    dir_d    = dir_q;
    speed_d  = speed_q;
    shots_d  = shots_q;
    hits_d   = hits_q;
    idx_d    = idx_q;
    round_d  = round_q;
    score_d  = score_q;

    // Dropping enable aborts everything; score and round survive until the next start.
    if (state_q != S_IDLE && !game_enable_i) begin
      state_d = S_IDLE;
      shots_d = '0;
      hits_d  = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (game_enable_i) begin
            round_d = 4'd1;
            score_d = '0;
            hits_d  = '0;
            idx_d   = '0;
            delay_d = delay_load;
            state_d = S_SPAWN_WAIT;
          end
        end
        S_SPAWN_WAIT: begin
          if (delay_q == '0) begin
            xpos_d   = XMIN_C + {3'b000, random_i[8:0]};
            dir_d    = random_i[15];
            speed_d  = (round_q == 4'hF) ? 4'hF : round_q + 4'd1;
            shots_d  = SHOTS_C;
            flight_d = FLIGHT_C;
            spawn_d  = 1'b1;
            state_d  = S_FLIGHT;
          end else if (frame_tick_i) begin
            delay_d = delay_q - 7'd1;
          end
        end
        S_FLIGHT: begin
          if (shot && shots_q != '0) begin
            shots_d = shots_q - 2'd1;
          end
          if (frame_tick_i && flight_q != '0) begin
            flight_d = flight_q - 10'd1;
          end
          // A hit wins over a simultaneous last shot or flight expiry.
          if (duck_hit_i) begin
            hit_d   = 1'b1;
            state_d = S_RESULT;
          end else if (shots_d == '0 || flight_d == '0) begin
            hit_d   = 1'b0;
            state_d = S_RESULT;
          end
        end
        S_RESULT: begin
          if (hit_q) begin
            hits_d  = hits_q + 4'd1;
            score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
          end
          idx_d = idx_q + 4'd1;
          if (idx_d == DUCKS_C) begin
            state_d = S_ROUND_END;
          end else begin
            delay_d = delay_load;
            state_d = S_SPAWN_WAIT;
          end
        end
        S_ROUND_END: begin
          if (hits_q >= PASS_C && round_q < MAXR_C) begin
            round_d = round_q + 4'd1;
            hits_d  = '0;
            idx_d   = '0;
            delay_d = delay_load;
            state_d = S_SPAWN_WAIT;
          end else begin
            state_d = S_FINISHED;
          end
        end
        S_FINISHED: begin
          state_d = S_FINISHED;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    active_d   = (state_d == S_FLIGHT);
    finished_d = (state_d == S_FINISHED);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      delay_q    <= '0;
      flight_q   <= '0;
      mouse_q    <= 1'b0;
      hit_q      <= 1'b0;
      spawn_q    <= 1'b0;
      active_q   <= 1'b0;
      xpos_q     <= '0;
      dir_q      <= 1'b0;
      speed_q    <= '0;
      shots_q    <= '0;
      hits_q     <= '0;
      idx_q      <= '0;
      round_q    <= '0;
      score_q    <= '0;
      finished_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      delay_q    <= delay_d;
      flight_q   <= flight_d;
      mouse_q    <= mouse_d;
      hit_q      <= hit_d;
      spawn_q    <= spawn_d;
      active_q   <= active_d;
      xpos_q     <= xpos_d;
      dir_q      <= dir_d;
      speed_q    <= speed_d;
      shots_q    <= shots_d;
      hits_q     <= hits_d;
      idx_q      <= idx_d;
      round_q    <= round_d;
      score_q    <= score_d;
      finished_q <= finished_d;
    end
  end

  assign duck_spawn_o      = spawn_q;
  assign duck_active_o     = active_q;
  assign duck_xpos_start_o = xpos_q;
  assign duck_dir_o        = dir_q;
  assign duck_speed_o      = speed_q;
  assign shots_left_o      = shots_q;
  assign hit_count_o       = hits_q;
  assign duck_index_o      = idx_q;
  assign round_o           = round_q;
  assign score_o           = score_q;
  assign game_finished_o   = finished_q;

endmodule

// File: tb/tb_duck_round_scheduler.sv
// Bench for duck_round_scheduler: per-cycle comparison against a game-level model of
// instance A (default parameters) plus literal checks, and a single-round instance B.
module tb_duck_round_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en_a = 1'b0, en_b = 1'b0;
  logic tick = 1'b0, lm = 1'b0, hit = 1'b0;
  logic [15:0] rnd = 16'h0000;

  logic a_spawn, a_active, a_dir, a_fin;
  logic [11:0] a_xpos;
  logic [3:0] a_speed, a_hits, a_idx, a_round;
  logic [1:0] a_shots;
  logic [15:0] a_score;
  logic b_spawn, b_active, b_dir, b_fin;
  logic [11:0] b_xpos;
  logic [3:0] b_speed, b_hits, b_idx, b_round;
  logic [1:0] b_shots;
  logic [15:0] b_score;

  int n_cmp = 0;
  int n_bad = 0;
  int tcnt = 0;
  int duck_k = 0;

  always #5 clk = ~clk;

  duck_round_scheduler dut_a (
    .clk_i(clk), .rst_i(rst), .game_enable_i(en_a), .frame_tick_i(tick),
    .random_i(rnd), .left_mouse_i(lm), .duck_hit_i(hit),
    .duck_spawn_o(a_spawn), .duck_active_o(a_active), .duck_xpos_start_o(a_xpos),
    .duck_dir_o(a_dir), .duck_speed_o(a_speed), .shots_left_o(a_shots),
    .hit_count_o(a_hits), .duck_index_o(a_idx), .round_o(a_round),
    .score_o(a_score), .game_finished_o(a_fin)
  );

  duck_round_scheduler #(.MAX_ROUND(1)) dut_b (
    .clk_i(clk), .rst_i(rst), .game_enable_i(en_b), .frame_tick_i(tick),
    .random_i(rnd), .left_mouse_i(lm), .duck_hit_i(hit),
    .duck_spawn_o(b_spawn), .duck_active_o(b_active), .duck_xpos_start_o(b_xpos),
    .duck_dir_o(b_dir), .duck_speed_o(b_speed), .shots_left_o(b_shots),
    .hit_count_o(b_hits), .duck_index_o(b_idx), .round_o(b_round),
    .score_o(b_score), .game_finished_o(b_fin)
  );

  // Frame tick every third cycle.
  initial forever begin
    @(negedge clk);
    tcnt++;
    tick = (tcnt % 3 == 0);
  end

  // Game-level model of instance A: counts ticks waited/elapsed and shots fired.
  localparam int M_IDLE = 0, M_WAIT = 1, M_FLY = 2, M_RES = 3, M_REND = 4, M_DONE = 5;
  int ph, waited, target, fired, elapsed;
  bit got, prev;
  int e_spawn, e_xpos, e_dir, e_speed, e_shots, e_hits, e_idx, e_round, e_score;

  always @(posedge clk or posedge rst) begin
    bit shot;
    if (rst) begin
      ph = M_IDLE; waited = 0; target = 0; fired = 0; elapsed = 0; got = 0; prev = 0;
      e_spawn = 0; e_xpos = 0; e_dir = 0; e_speed = 0; e_shots = 0;
      e_hits = 0; e_idx = 0; e_round = 0; e_score = 0;
    end else begin
      shot = lm && !prev;
      prev = lm;
      e_spawn = 0;
      if (!en_a && ph != M_IDLE) begin
        ph = M_IDLE; e_shots = 0; e_hits = 0; e_idx = 0;
      end else begin
        case (ph)
          M_IDLE: if (en_a) begin
            e_round = 1; e_score = 0; e_hits = 0; e_idx = 0;
            target = 30 + (int'(rnd) % 32); waited = 0; ph = M_WAIT;
          end
          M_WAIT: if (waited == target) begin
            e_xpos = 64 + (int'(rnd) % 512);
            e_dir = int'(rnd) / 32768;
            e_speed = (e_round + 1 > 15) ? 15 : e_round + 1;
            fired = 0; elapsed = 0; e_shots = 3; e_spawn = 1; ph = M_FLY;
          end else if (tick) begin
            waited++;
          end
          M_FLY: begin
            if (shot) fired++;
            if (tick) elapsed++;
            e_shots = 3 - fired;
            if (hit) begin got = 1; ph = M_RES; end
            else if (fired >= 3 || elapsed >= 300) begin got = 0; ph = M_RES; end
          end
          M_RES: begin
            if (got) begin
              e_hits++;
              e_score = (e_score + 100 > 65535) ? 65535 : e_score + 100;
            end
            e_idx++;
            if (e_idx == 10) ph = M_REND;
            else begin target = 30 + (int'(rnd) % 32); waited = 0; ph = M_WAIT; end
          end
          M_REND: begin
            if (e_hits >= 6 && e_round < 9) begin
              e_round++; e_hits = 0; e_idx = 0;
              target = 30 + (int'(rnd) % 32); waited = 0; ph = M_WAIT;
            end else begin
              ph = M_DONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    int ea, ef;
    ea = (ph == M_FLY) ? 1 : 0;
    ef = (ph == M_DONE) ? 1 : 0;
    n_cmp++;
    if (int'(a_spawn) != e_spawn || int'(a_active) != ea || int'(a_xpos) != e_xpos ||
        int'(a_dir) != e_dir || int'(a_speed) != e_speed || int'(a_shots) != e_shots ||
        int'(a_hits) != e_hits || int'(a_idx) != e_idx || int'(a_round) != e_round ||
        int'(a_score) != e_score || int'(a_fin) != ef) begin
      n_bad++;
      if (n_bad <= 20)
        $display("FAIL model_cycle t=%0t got sp%0d ac%0d x%0d d%0d v%0d sh%0d h%0d i%0d r%0d s%0d f%0d want sp%0d ac%0d x%0d d%0d v%0d sh%0d h%0d i%0d r%0d s%0d f%0d",
                 $time, a_spawn, a_active, a_xpos, a_dir, a_speed, a_shots, a_hits, a_idx,
                 a_round, a_score, a_fin, e_spawn, ea, e_xpos, e_dir, e_speed, e_shots,
                 e_hits, e_idx, e_round, e_score, ef);
    end
  end

  task automatic chk(input string nm, input int got_v, input int want_v);
    n_cmp++;
    if (got_v != want_v) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, got_v, want_v);
    end
  endtask

  function automatic bit act(input int s);
    return (s != 0) ? b_active : a_active;
  endfunction

  task automatic wait_active(input int s, input bit lvl, input int budget, input string nm);
    int n;
    n = 0;
    while (act(s) != lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (act(s) != lvl) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timeout after %0d cycles, active=%0b want %0b", nm, n, act(s), lvl);
    end
  endtask

  // One duck: nshots clicks, then optionally a hit (or a hit on the last click).
  task automatic duck(input int s, input int nshots, input bit do_hit, input bit coincide);
    if (!act(s)) begin
      duck_k++;
      rnd = 16'(duck_k * 40503 + 17);
      wait_active(s, 1'b1, 600, "spawn");
    end
    for (int i = 0; i < nshots; i++) begin
      lm = 1'b1;
      if (coincide && do_hit && i == nshots - 1) hit = 1'b1;
      @(negedge clk);
      lm = 1'b0;
      hit = 1'b0;
      @(negedge clk);
    end
    if (do_hit && !coincide) begin
      hit = 1'b1;
      @(negedge clk);
      hit = 1'b0;
    end
    wait_active(s, 1'b0, 1200, "flight_end");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_round", int'(a_round), 0);
    chk("reset_score", int'(a_score), 0);
    rst = 1'b0;
    en_a = 1'b1;
    rnd = 16'h8005;
    wait_active(0, 1'b1, 600, "first_spawn");
    chk("spawn_xpos", int'(a_xpos), 69);
    chk("spawn_dir", int'(a_dir), 1);

    // Asynchronous reset in the middle of a flight.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_active", int'(a_active), 0);
    chk("async_rst_shots", int'(a_shots), 0);
    chk("async_rst_round", int'(a_round), 0);
    chk("async_rst_xpos", int'(a_xpos), 0);
    @(negedge clk);
    rst = 1'b0;

    wait_active(0, 1'b1, 600, "restart_spawn");
    chk("restart_spawn_pulse", int'(a_spawn), 1);
    chk("restart_xpos", int'(a_xpos), 69);
    chk("restart_dir", int'(a_dir), 1);
    chk("restart_speed", int'(a_speed), 2);
    chk("restart_shots", int'(a_shots), 3);

    // Hit path: one shot, then hit.
    duck(0, 1, 1'b1, 1'b0);
    chk("hit_shots_left", int'(a_shots), 2);
    chk("hit_active_low", int'(a_active), 0);
    @(negedge clk);
    chk("hit_count", int'(a_hits), 1);
    chk("hit_score", int'(a_score), 100);
    chk("hit_index", int'(a_idx), 1);

    duck(0, 3, 1'b0, 1'b0);
    @(negedge clk);
    chk("miss_score", int'(a_score), 100);
    chk("miss_index", int'(a_idx), 2);

    duck(0, 0, 1'b0, 1'b0);
    @(negedge clk);
    chk("escape_hits", int'(a_hits), 1);
    chk("escape_index", int'(a_idx), 3);

    duck(0, 3, 1'b1, 1'b1);
    @(negedge clk);
    chk("coincide_hits", int'(a_hits), 2);
    chk("coincide_score", int'(a_score), 200);

    for (int i = 0; i < 4; i++) duck(0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) duck(0, 3, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("round2_round", int'(a_round), 2);
    chk("round2_hits", int'(a_hits), 0);
    chk("round2_index", int'(a_idx), 0);
    chk("round2_score", int'(a_score), 600);

    for (int i = 0; i < 5; i++) duck(0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) duck(0, 3, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("fail_finished", int'(a_fin), 1);
    chk("fail_score", int'(a_score), 1100);
    chk("fail_round", int'(a_round), 2);

    // Abort from FINISHED keeps score and round.
    en_a = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_fin_clear", int'(a_fin), 0);
    chk("abort_score_hold", int'(a_score), 1100);
    chk("abort_round_hold", int'(a_round), 2);

    en_a = 1'b1;
    rnd = 16'h0003;
    wait_active(0, 1'b1, 600, "abort_spawn");
    chk("restart_score", int'(a_score), 0);
    lm = 1'b1;
    repeat (5) @(negedge clk);
    lm = 1'b0;
    @(negedge clk);
    chk("held_mouse_one_shot", int'(a_shots), 2);
    en_a = 1'b0;
    @(negedge clk);
    chk("abort_active", int'(a_active), 0);
    chk("abort_shots", int'(a_shots), 0);
    chk("abort_round", int'(a_round), 1);

    // Shots and hits during SPAWN_WAIT are ignored.
    en_a = 1'b1;
    repeat (2) @(negedge clk);
    lm = 1'b1;
    hit = 1'b1;
    @(negedge clk);
    lm = 1'b0;
    hit = 1'b0;
    repeat (2) @(negedge clk);
    chk("wait_hits", int'(a_hits), 0);
    chk("wait_shots", int'(a_shots), 0);
    chk("wait_score", int'(a_score), 0);
    wait_active(0, 1'b1, 600, "wait_then_spawn");
    chk("wait_then_shots", int'(a_shots), 3);
    en_a = 1'b0;
    repeat (3) @(negedge clk);

    // Single-round instance: ten hits end the game in round 1.
    en_b = 1'b1;
    for (int i = 0; i < 10; i++) duck(1, 0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    chk("final_finished", int'(b_fin), 1);
    chk("final_round", int'(b_round), 1);
    chk("final_score", int'(b_score), 1000);
    chk("final_hits", int'(b_hits), 10);
    en_b = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/duck_round_scheduler.md
# duck_round_scheduler

Sequences Duck Hunt gameplay once the game-control FSM enables play. It schedules each duck flight using the LFSR random word, and generates spawn parameters for the duck renderer. It also tracks shots, hits, rounds and score, and raises `game_finished` back to the game-control FSM. It sits between the game-control FSM, the LFSR, the mouse inputs and the duck draw/hit-detect datapath.

## Interface
- `DUCKS_PER_ROUND`, 10: ducks per round, 1..15.
- `SHOTS_PER_DUCK`, 3: shots allowed per duck, 1..3.
- `PASS_HITS`, 6: hits needed to advance a round.
- `MAX_ROUND`, 9: last round, 1..15.
- `SPAWN_BASE`, 30: minimum spawn delay, in frame ticks.
- `FLIGHT_TICKS`, 300: flight time before a duck escapes, in frame ticks.
- `X_MIN`, 64: leftmost spawn x position.
- `HIT_POINTS`, 100: score added per hit.

- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `game_enable` in 1: level; play allowed while high.
- `frame_tick` in 1: one-cycle pulse, once per frame.
- `random` in 16: LFSR output, sampled when needed.
- `left_mouse` in 1: level, synchronous to `clk`.
- `duck_hit` in 1: one-cycle pulse from hit detection.
- `duck_spawn` out 1: one-cycle pulse when a flight starts.
- `duck_active` out 1: high throughout a flight.
- `duck_xpos_start` out 12: spawn x position.
- `duck_dir` out 1: 0 = flies right, 1 = flies left.
- `duck_speed` out 4: pixels per frame.
- `shots_left` out 2: shots remaining for the current duck.
- `hit_count` out 4: hits in the current round.
- `duck_index` out 4: ducks completed in the current round.
- `round` out 4: current round.
- `score` out 16: total score.
- `game_finished` out 1: level; game over.

## Operation
States: IDLE, SPAWN_WAIT, FLIGHT, RESULT, ROUND_END, FINISHED.

- **IDLE**
  - Outputs hold reset values.
  - When `game_enable` = 1: `round` ← 1, `score` ← 0, `hit_count` ← 0, `duck_index` ← 0.
  - Load the delay counter with `SPAWN_BASE + random[4:0]`, then go to SPAWN_WAIT.
- **SPAWN_WAIT**
  - Decrement the delay counter on each `frame_tick`.
  - When the counter is 0, go to FLIGHT and, in the same edge:
    - latch `duck_xpos_start` = `X_MIN + random[8:0]` (zero-extended);
    - latch `duck_dir` = `random[15]`;
    - latch `duck_speed` = `round + 1`, saturating at 15;
    - set `shots_left` = `SHOTS_PER_DUCK`;
    - load the flight counter with `FLIGHT_TICKS`;
    - pulse `duck_spawn`.
- **FLIGHT**
  - `duck_active` = 1.
  - A shot is a cycle with `left_mouse` = 1 and the registered previous `left_mouse` = 0. Each shot decrements `shots_left`.
  - `frame_tick` decrements the flight counter.
  - Exit to RESULT on the first of:
    - `duck_hit` → hit;
    - `shots_left` reaching 0 → miss;
    - flight counter reaching 0 → escape (miss).
- **RESULT** (one cycle)
  - On a hit: `hit_count` += 1, and `score` += `HIT_POINTS`, saturating at 16'hFFFF.
  - `duck_index` += 1.
  - If `duck_index` (new value) = `DUCKS_PER_ROUND`, go to ROUND_END.
  - Otherwise reload the delay counter from `random` and go to SPAWN_WAIT.
- **ROUND_END** (one cycle)
  - If `hit_count` ≥ `PASS_HITS` and `round` < `MAX_ROUND`: `round` += 1, clear `hit_count` and `duck_index`, reload the delay counter, go to SPAWN_WAIT.
  - Otherwise go to FINISHED.
- **FINISHED**
  - `game_finished` = 1 and `duck_active` = 0.
  - `score` and `round` hold their values.

Priority and abort rules:
- **Hit versus shot:** `duck_hit` in the same cycle as the last shot, or as flight-counter expiry, counts as a hit.
- **Hit outside FLIGHT:** `duck_hit` is ignored in every other state.
- **Extra shots:** shots are ignored outside FLIGHT, and `shots_left` never underflows.
- **Abort:** `game_enable` = 0 in any non-IDLE state → IDLE on the next edge.
  - Flight and status outputs clear: `duck_active`, `game_finished`, `shots_left`, `hit_count`, `duck_index`.
  - `score` and `round` hold until the next start.

## Timing
- **Reset values:** all outputs 0, state IDLE, `left_mouse` history register 0.
- **Registered outputs:** all outputs are registered, and every state transition takes effect on the edge after its condition.
- **Spawn:**
  - `duck_spawn` is high for exactly the first FLIGHT cycle.
  - `duck_active` rises in the same cycle as `duck_spawn`.
  - `duck_xpos_start`, `duck_dir` and `duck_speed` are valid from that cycle and stable until the next spawn.
- **Shot latency:** `shots_left` updates one cycle after the detected `left_mouse` rising edge.
- **Hit latency:** `duck_active` falls one cycle after `duck_hit`, and `hit_count`/`score` update one cycle later (RESULT).
- **`random` sampling:** only at delay loads and at spawn.
- **Counter arithmetic:**
  - The delay counter is 7 bits and the flight counter is 10 bits.
  - Both decrement only on `frame_tick`.

## Test plan
- **Reset, then start:**
  - Assert `rst` mid-FLIGHT → all outputs 0 asynchronously.
  - Release `rst`, raise `game_enable` with `random` = 16'h8005 → SPAWN_WAIT for 35 ticks.
  - Then expect `duck_spawn` with `duck_xpos_start` = 69, `duck_dir` = 1, `duck_speed` = 2.
- **Hit path:**
  - Fire one shot, then `duck_hit` → `shots_left` = 2, `duck_active` falls.
  - Expect `hit_count` = 1, `score` = 100, `duck_index` = 1.
- **Miss paths:**
  - Fire 3 shots with no hit → miss, `score` unchanged.
  - Separately, fire no shots for `FLIGHT_TICKS` ticks → escape, `hit_count` unchanged.
  - Third shot coincident with `duck_hit` → counted as a hit.
- **Round advance and fail:**
  - 6 hits and 4 misses → `round` = 2, counters cleared.
  - Next round with 5 hits → FINISHED, `game_finished` = 1, `score` = 1100.
- **Final round:**
  - With `MAX_ROUND` = 1, 10 hits → FINISHED, `round` = 1, `score` = 1000.
- **Abort:**
  - Drop `game_enable` mid-FLIGHT → IDLE next edge, `duck_active` = 0.
  - Held `left_mouse` counts as exactly one shot; extra shots and `duck_hit` in SPAWN_WAIT have no effect.
